// File: rtl/oam_dma_arbiter_pkg.sv
// Shared types and constants for the OAM DMA bus arbiter.
// Imported by the arbiter top and its address decoder.
package oam_dma_arbiter_pkg;

    localparam logic [15:0] DMA_REG_ADR = 16'hFF46;
    localparam logic [15:0] OAM_BASE    = 16'hFE00;
    localparam logic [15:0] HRAM_LO     = 16'hFF80;
    localparam logic [15:0] HRAM_HI     = 16'hFFFE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_e;

    typedef enum logic [1:0] {
        CLS_MAIN = 2'd0,
        CLS_HRAM = 2'd1,
        CLS_REG  = 2'd2
    } adr_class_e;

    localparam logic [1:0] PH_READ  = 2'd0;
    localparam logic [1:0] PH_LATCH = 2'd1;
    localparam logic [1:0] PH_WRITE = 2'd2;
    localparam logic [1:0] PH_NEXT  = 2'd3;

    // Pages 0xE0-0xFF alias work RAM at 0xC0-0xDF (echo region).
    function automatic logic [7:0] src_page(input logic [7:0] r);
        return (r >= 8'hE0) ? (r & 8'hDF) : r;
    endfunction

endpackage

// File: rtl/oam_dma_addr_decode.sv
// Classifies a CPU address as HRAM, DMA register or main bus.
// Purely combinational; shared by IO blocks that need the same split.
module oam_dma_addr_decode
    import oam_dma_arbiter_pkg::*;
(
    input  logic [15:0] cpu_adr,
    output adr_class_e  cls
);

    always_comb begin
        cls = CLS_MAIN;
        if (cpu_adr == DMA_REG_ADR) begin
            cls = CLS_REG;
        end else if (cpu_adr >= HRAM_LO && cpu_adr <= HRAM_HI) begin
            cls = CLS_HRAM;
        end
    end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Main bus arbiter with the 0xFF46 OAM DMA engine; HRAM stays on its
// own port so the CPU can run from HRAM while DMA owns the bus.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter int XFER_BYTES  = 160,
    parameter int START_DELAY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_ddrv,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [7:0]  cpu_data,
    output logic [15:0] adr,
    output logic [7:0]  dout,
    output logic        ddrv,
    output logic        read,
    output logic        write,
    input  logic [7:0]  data,
    output logic [6:0]  hram_adr,
    output logic        hram_read,
    output logic        hram_write,
    output logic [7:0]  hram_dout,
    input  logic [7:0]  hram_data,
    output logic        dma_active
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_BYTES - 1);
    localparam logic [7:0] LAST_CNT = 8'(START_DELAY - 1);

    adr_class_e cls;
    dma_state_e state;
    logic [7:0] dma_reg;
    logic [7:0] idx;
    logic [7:0] cnt;
    logic [7:0] byte_q;
    logic [1:0] phase;
    logic       prev_write;
    logic [15:0] bus_adr;
    logic [7:0]  bus_dout;
    logic        bus_ddrv;
    logic        bus_read;
    logic        bus_write;
    logic        is_hram;
    logic        is_reg;
    logic        is_main;
    logic        reg_wr;

    oam_dma_addr_decode u_dec (
        .cpu_adr (cpu_adr),
        .cls     (cls)
    );

    assign is_hram = (cls == CLS_HRAM);
    assign is_reg  = (cls == CLS_REG);
    assign is_main = (cls == CLS_MAIN);
    assign reg_wr  = cpu_write & ~prev_write & is_reg;

    assign hram_adr   = cpu_adr[6:0];
    assign hram_read  = cpu_read & is_hram;
    assign hram_write = cpu_write & is_hram;
    assign hram_dout  = cpu_dout;

    always_comb begin
        cpu_data = 8'hFF;
        if (is_hram) begin
            cpu_data = hram_data;
        end else if (is_reg) begin
            cpu_data = dma_reg;
        end else if (state == IDLE) begin
            cpu_data = data;
        end
    end

    always_comb begin
        adr   = bus_adr;
        dout  = bus_dout;
        ddrv  = bus_ddrv;
        read  = bus_read;
        write = bus_write;
        if (state == IDLE) begin
            adr   = cpu_adr;
            dout  = cpu_dout;
            ddrv  = cpu_ddrv & is_main;
            read  = cpu_read & is_main;
            write = cpu_write & is_main;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            dma_reg    <= 8'h00;
            idx        <= 8'h00;
            cnt        <= 8'h00;
            phase      <= PH_READ;
            byte_q     <= 8'h00;
            prev_write <= 1'b0;
            dma_active <= 1'b0;
            bus_adr    <= 16'h0000;
            bus_dout   <= 8'h00;
            bus_ddrv   <= 1'b0;
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
        end else begin
            prev_write <= cpu_write;
            // A register write always (re)starts, even on the last edge.
            if (reg_wr) begin
                dma_reg    <= cpu_dout;
                state      <= START;
                cnt        <= 8'h00;
                idx        <= 8'h00;
                phase      <= PH_READ;
                dma_active <= 1'b1;
                bus_ddrv   <= 1'b0;
                bus_read   <= 1'b0;
                bus_write  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    START: begin
                        if (cnt == LAST_CNT) begin
                            state    <= XFER;
                            idx      <= 8'h00;
                            phase    <= PH_READ;
                            bus_adr  <= {src_page(dma_reg), 8'h00};
                            bus_read <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    XFER: begin
                        unique case (phase)
                            PH_READ: begin
                                byte_q   <= data;
                                bus_read <= 1'b0;
                                phase    <= PH_LATCH;
                            end
                            PH_LATCH: begin
                                bus_adr   <= OAM_BASE + {8'h00, idx};
                                bus_dout  <= byte_q;
                                bus_ddrv  <= 1'b1;
                                bus_write <= 1'b1;
                                phase     <= PH_WRITE;
                            end
                            PH_WRITE: begin
                                bus_write <= 1'b0;
                                bus_ddrv  <= 1'b0;
                                phase     <= PH_NEXT;
                            end
                            PH_NEXT: begin
                                phase <= PH_READ;
                                if (idx == LAST_IDX) begin
                                    state      <= IDLE;
                                    idx        <= 8'h00;
                                    dma_active <= 1'b0;
                                end else begin
                                    idx      <= idx + 8'd1;
                                    bus_adr  <= {src_page(dma_reg), idx + 8'd1};
                                    bus_read <= 1'b1;
                                end
                            end
                        endcase
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: IDLE vector table plus
// multi-cycle DMA, lockout, restart, echo and async-reset sequences.
module tb_oam_dma_arbiter;

    localparam int XB  = 160;
    localparam int SD  = 4;
    localparam int OCC = SD + 4 * XB;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] cpu_adr;
    logic [7:0]  cpu_dout;
    logic        cpu_ddrv;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_data;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic        ddrv;
    logic        read;
    logic        write;
    logic [7:0]  data;
    logic [6:0]  hram_adr;
    logic        hram_read;
    logic        hram_write;
    logic [7:0]  hram_dout;
    logic [7:0]  hram_data;
    logic        dma_active;

    oam_dma_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_adr    (cpu_adr),
        .cpu_dout   (cpu_dout),
        .cpu_ddrv   (cpu_ddrv),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_data   (cpu_data),
        .adr        (adr),
        .dout       (dout),
        .ddrv       (ddrv),
        .read       (read),
        .write      (write),
        .data       (data),
        .hram_adr   (hram_adr),
        .hram_read  (hram_read),
        .hram_write (hram_write),
        .hram_dout  (hram_dout),
        .hram_data  (hram_data),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [65536];
    bit         mem_v [65536];
    bit [7:0]   hram [128];
    int cyc;
    int rd_cnt;
    int wr_cnt;
    int act_cnt;
    int checks;
    int errors;

    function automatic logic [7:0] pat(input logic [15:0] a);
        if (a == 16'h0150) return 8'h3C;
        if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
        return a[7:0] ^ a[15:8];
    endfunction

    assign data      = mem_v[adr] ? mem[adr] : pat(adr);
    assign hram_data = hram[hram_adr];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (read === 1'b1) rd_cnt <= rd_cnt + 1;
        if (dma_active === 1'b1) act_cnt <= act_cnt + 1;
        if (write === 1'b1) begin
            wr_cnt     <= wr_cnt + 1;
            mem[adr]   <= dout;
            mem_v[adr] <= 1'b1;
        end
        if (hram_write === 1'b1) hram[hram_adr] <= hram_dout;
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  wd;
        logic        rd;
        logic        wr;
        logic [4:0]  e_str;
        logic        chk_d;
        logic [7:0]  e_d;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic cpu_idle();
        cpu_adr   = 16'h0000;
        cpu_dout  = 8'h00;
        cpu_ddrv  = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cpu_adr   = a;
        cpu_dout  = d;
        cpu_ddrv  = 1'b1;
        cpu_write = 1'b1;
        sync();
        cpu_write = 1'b0;
        cpu_ddrv  = 1'b0;
        sync();
    endtask

    task automatic cpu_rd_chk(input logic [15:0] a, input logic [7:0] e,
                              input string nm);
        cpu_adr  = a;
        cpu_read = 1'b1;
        #1;
        chk(nm, cpu_data, e);
        sync();
        cpu_read = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (dma_active === 1'b1 && n < 1000) begin
            sync();
            n++;
        end
        chk(nm, dma_active, 0);
    endtask

    task automatic oam_chk(input string nm, input logic [7:0] key);
        int bad = 0;
        for (int i = 0; i < XB; i++) begin
            logic [15:0] a;
            a = 16'hFE00 + 16'(i);
            if (!mem_v[a] || mem[a] !== (8'(i) ^ key)) bad++;
        end
        chk(nm, bad, 0);
    endtask

    initial begin
        int a0, r0, w0, c_first, c_second, n;
        checks = 0;
        errors = 0;

        vecs[0] = '{16'h0150, 8'h00, 1'b1, 1'b0, 5'b10000, 1'b1, 8'h3C, "pt_rd0150"};
        vecs[1] = '{16'hC000, 8'h77, 1'b0, 1'b1, 5'b01100, 1'b0, 8'h00, "pt_wrC000"};
        vecs[2] = '{16'hC000, 8'h00, 1'b1, 1'b0, 5'b10000, 1'b1, 8'h77, "pt_rdC000"};
        vecs[3] = '{16'hFFFE, 8'h5C, 1'b0, 1'b1, 5'b00001, 1'b0, 8'h00, "hr_wrFFFE"};
        vecs[4] = '{16'hFFFE, 8'h00, 1'b1, 1'b0, 5'b00010, 1'b1, 8'h5C, "hr_rdFFFE"};
        vecs[5] = '{16'hFF80, 8'h00, 1'b1, 1'b0, 5'b00010, 1'b1, 8'h00, "hr_rdFF80"};
        vecs[6] = '{16'hFF7F, 8'h00, 1'b1, 1'b0, 5'b10000, 1'b1, 8'h80, "pt_rdFF7F"};
        vecs[7] = '{16'hFFFF, 8'h00, 1'b1, 1'b0, 5'b10000, 1'b1, 8'h00, "pt_rdFFFF"};
        vecs[8] = '{16'hFF46, 8'h00, 1'b1, 1'b0, 5'b00000, 1'b1, 8'h00, "reg_rd"};
        vecs[9] = '{16'hFF47, 8'h00, 1'b1, 1'b0, 5'b10000, 1'b1, 8'hB8, "pt_rdFF47"};

        reset = 1'b0;
        cpu_idle();
        sync();
        sync();
        chk("rst_state", {read, write, ddrv, dma_active}, 0);
        reset = 1'b1;
        sync();

        for (int i = 0; i < 10; i++) begin
            cpu_adr   = vecs[i].a;
            cpu_dout  = vecs[i].wd;
            cpu_read  = vecs[i].rd;
            cpu_write = vecs[i].wr;
            cpu_ddrv  = vecs[i].wr;
            #1;
            chk({vecs[i].name, "_str"},
                {read, write, ddrv, hram_read, hram_write}, vecs[i].e_str);
            if (vecs[i].e_str[4] || vecs[i].e_str[3])
                chk({vecs[i].name, "_adr"}, adr, vecs[i].a);
            if (vecs[i].e_str[3])
                chk({vecs[i].name, "_dout"}, dout, vecs[i].wd);
            if (vecs[i].chk_d)
                chk({vecs[i].name, "_data"}, cpu_data, vecs[i].e_d);
            chk({vecs[i].name, "_act"}, dma_active, 0);
            sync();
        end
        cpu_idle();
        sync();

        // Full DMA from 0xC100 with CPU lockout and HRAM traffic.
        a0 = act_cnt;
        r0 = rd_cnt;
        w0 = wr_cnt;
        cpu_wr(16'hFF46, 8'hC1);
        chk("dma_act_hi", dma_active, 1);
        cpu_adr  = 16'h8000;
        cpu_read = 1'b1;
        #1;
        chk("lock_rd_data", cpu_data, 8'hFF);
        chk("lock_rd_strobe", read, 0);
        sync();
        cpu_read = 1'b0;
        cpu_wr(16'hC000, 8'h11);
        cpu_wr(16'hFF90, 8'hA5);
        cpu_rd_chk(16'hFF90, 8'hA5, "lock_hram_rd");
        wait_done("full_done");
        chk("full_active", act_cnt - a0, OCC);
        chk("full_reads", rd_cnt - r0, XB);
        chk("full_writes", wr_cnt - w0, XB);
        chk("lock_wr_drop", mem[16'hC000], 8'h77);
        oam_chk("full_oam", 8'h5A);

        // Echo page fold and register readback.
        c_first = cyc;
        cpu_wr(16'hFF46, 8'hE3);
        cpu_rd_chk(16'hFF46, 8'hE3, "echo_reg_rd");
        n = 0;
        while (read !== 1'b1 && n < 1000) begin
            sync();
            n++;
        end
        chk("echo_first_adr", adr, 16'hC300);
        chk("echo_first_dly", cyc - c_first, SD + 1);
        wait_done("echo_done");
        oam_chk("echo_oam", 8'hC3);

        // Restart from 0xD200 while fetching idx 50 of 0xC100.
        a0 = act_cnt;
        c_first = cyc;
        cpu_wr(16'hFF46, 8'hC1);
        n = 0;
        while (!(read === 1'b1 && adr === 16'hC132) && n < 1000) begin
            sync();
            n++;
        end
        chk("rs_seen_idx50", {read, adr}, {1'b1, 16'hC132});
        c_second = cyc;
        cpu_wr(16'hFF46, 8'hD2);
        n = 0;
        while (read !== 1'b1 && n < 1000) begin
            sync();
            n++;
        end
        chk("rs_first_adr", adr, 16'hD200);
        wait_done("rs_done");
        chk("rs_active", act_cnt - a0, (c_second - c_first) + OCC);
        oam_chk("rs_oam", 8'hD2);

        // Register write lands on the final phase-3 edge.
        a0 = act_cnt;
        c_first = cyc;
        cpu_wr(16'hFF46, 8'hC1);
        while (cyc - c_first < OCC) sync();
        cpu_wr(16'hFF46, 8'h1C);
        wait_done("sim_done");
        chk("sim_active", act_cnt - a0, 2 * OCC);
        oam_chk("sim_oam", 8'h1C);

        // Asynchronous reset in the middle of the idx 80 write.
        cpu_wr(16'hFF46, 8'hC1);
        n = 0;
        while (!(write === 1'b1 && adr === 16'hFE50) && n < 1000) begin
            sync();
            n++;
        end
        chk("ar_seen_wr80", {write, adr}, {1'b1, 16'hFE50});
        reset = 1'b0;
        #1;
        chk("ar_strobes", {read, write, ddrv, dma_active}, 0);
        sync();
        reset = 1'b1;
        sync();
        cpu_rd_chk(16'hFF46, 8'h00, "ar_reg_rd");
        cpu_adr  = 16'h0100;
        cpu_read = 1'b1;
        #1;
        chk("ar_pt_bus", {read, adr}, {1'b1, 16'h0100});
        chk("ar_pt_data", cpu_data, 8'h01);
        sync();
        cpu_idle();
        chk("ar_oam_done", mem[16'hFE4F], 8'h15);
        chk("ar_oam_left", mem[16'hFE51], 8'h4D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Sits between the lr35902 core and the external memory bus, and owns bus arbitration.
- Implements the DMA register at 0xFF46. A CPU write to it copies 160 bytes from {val,8'h00} into OAM at 0xFE00, one byte per M-cycle (4 clk).
- While the copy runs, the CPU is locked out of the main bus. HRAM (0xFF80–0xFFFE) is always routed to a dedicated port, so the CPU can keep executing from HRAM.

Parameters:
- XFER_BYTES, 160, number of bytes copied per DMA.
- DMA_REG_ADR, 16'hFF46, address of the DMA source register.
- OAM_BASE, 16'hFE00, destination base address.
- START_DELAY, 4, clk cycles from trigger to the first DMA bus access.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- cpu_adr  in  16  CPU address.
- cpu_dout  in  8  CPU write data.
- cpu_ddrv  in  1  CPU drives data.
- cpu_read  in  1  CPU read strobe.
- cpu_write  in  1  CPU write strobe.
- cpu_data  out  8  read data returned to the CPU.
- adr  out  16  main bus address.
- dout  out  8  main bus write data.
- ddrv  out  1  main bus data drive.
- read  out  1  main bus read strobe.
- write  out  1  main bus write strobe.
- data  in  8  main bus read data.
- hram_adr  out  7  HRAM offset (cpu_adr[6:0]).
- hram_read  out  1  HRAM read strobe.
- hram_write  out  1  HRAM write strobe.
- hram_dout  out  8  HRAM write data.
- hram_data  in  8  HRAM read data.
- dma_active  out  1  high from trigger until the last OAM write completes.

Behaviour:
- Reset (reset=0):
  - state=IDLE, dma_reg=8'h00, idx=0, phase=0, dma_active=0.
  - DMA-side bus regs: adr=0, dout=0, ddrv=0, read=0, write=0.
- Address classes:
  - HRAM = 0xFF80..0xFFFE.
  - REG = DMA_REG_ADR.
  - MAIN = everything else.
- HRAM routing (always, in every state, combinational):
  - hram_* follow the cpu_* signals, gated by the HRAM class.
  - cpu_data=hram_data.
  - Main bus strobes stay low for HRAM accesses.
- REG access:
  - A write is detected on the rising edge of cpu_write (registered prev_write) with cpu_adr==DMA_REG_ADR. That clk: dma_reg<=cpu_dout, state<=START, cnt<=0, dma_active<=1.
  - A read returns dma_reg combinationally.
  - REG accesses never reach the main bus.
- IDLE:
  - Main bus outputs pass the cpu_* signals through combinationally for class MAIN.
  - cpu_data=data.
- START:
  - Waits START_DELAY clk, then goes to XFER with idx=0, phase=0.
  - The main bus is already owned by DMA and stays idle (strobes low).
- XFER, one byte per 4 clk, by phase:
  - 0: adr={src,idx}, read=1.
  - 1: latch byte<=data, read=0.
  - 2: adr=OAM_BASE+idx, dout=byte, ddrv=1, write=1.
  - 3: write=0, ddrv=0, idx<=idx+1.
  - At phase 3 with idx==XFER_BYTES-1: state<=IDLE, dma_active<=0 on the same edge.
- Total occupancy is START_DELAY + 4*XFER_BYTES clk (644 by default).
- Source high byte: src = dma_reg>=8'hE0 ? dma_reg&8'hDF : dma_reg (echo fold). idx is 8-bit; the source low byte equals idx and never wraps.
- CPU lockout while state!=IDLE:
  - MAIN reads return cpu_data=8'hFF.
  - MAIN writes are dropped.
  - The CPU never sees a stall.
- Restart: a REG write while START or XFER re-latches dma_reg and returns to START with cnt=0, idx=0, phase=0. Any write left half-done (phase 2) is deasserted next clk. dma_active stays high throughout.
- Simultaneous events: a REG write on the final phase-3 edge wins, so the next state is START, not IDLE.
- Reset mid-transfer aborts immediately: all strobes go low asynchronously and OAM is left partially written.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, START, XFER);
  - DMA_REG_ADR, OAM_BASE, HRAM_LO=16'hFF80, HRAM_HI=16'hFFFE;
  - phase constants 0..3.
- One natural sub-module: oam_dma_addr_decode, a combinational class decode of cpu_adr into HRAM/REG/MAIN, reusable by later IO blocks.

Test Plan:
- Idle passthrough: CPU reads 0x0150 while the bus model returns 0x3C → adr=0x0150, read=1, cpu_data=0x3C; dma_active=0.
- Full DMA: CPU writes 0xC1 to 0xFF46; source RAM 0xC100+i = i^0x5A → after 644 clk, OAM 0xFE00+i = i^0x5A for i=0..159, with exactly 160 reads and 160 writes; dma_active high for exactly 644 clk.
- Lockout: during DMA, CPU reads 0x8000 → cpu_data=0xFF, no extra bus read; CPU writes 0xC000 → no bus write. CPU writes/reads 0xFF90=0xA5 via the HRAM port → read returns 0xA5.
- Restart: write 0xC1, then at idx=50 write 0xD2 → transfer restarts from 0xD200 and idx=0; final OAM holds 0xD2xx data; dma_active never drops.
- Echo fold and register read: write 0xE3 → reads come from 0xC300..0xC39F; CPU read of 0xFF46 returns 0xE3.
- Async reset at idx=80, phase 2 → write/ddrv/read low immediately, dma_active=0, dma_reg=0x00; the next CPU access to 0x0100 passes through.
